// File: rtl/prbs_wide_chk.sv
// prbs_wide_chk: wide-word PRBS checker with SEARCH/VERIFY/LOCKED sync FSM,
// per-word mismatch popcount and saturating error/word counters.
module prbs_wide_chk #(
  parameter int PN         = 7,
  parameter int WIDTH      = 128,
  parameter int LOCK_THR   = 4,
  parameter int UNLOCK_THR = 4,
  parameter int CNT_W      = 32,
  localparam int EBW       = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_s_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_inv,
  input  logic             i_clr_cnt,
  output logic             o_lock,
  output logic [EBW-1:0]   o_err_bits,
  output logic             o_err_word,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_word_cnt
);

  // Second feedback tap of each supported polynomial.
  localparam int TAP = (PN == 7)  ? 6  :
                       (PN == 9)  ? 5  :
                       (PN == 15) ? 14 :
                       (PN == 23) ? 18 : 28;
  // Sum width wide enough to detect overflow of either addend.
  localparam int SW  = ((CNT_W > EBW) ? CNT_W : EBW) + 1;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // Extend the PN-bit seed (bit 0 oldest) by WIDTH bits of the recurrence.
  function automatic logic [WIDTH-1:0] predict(input logic [PN-1:0] s);
    logic [PN+WIDTH-1:0] ext;
    ext = '0;
    ext[PN-1:0] = s;
    for (int i = 0; i < WIDTH; i++)
      ext[PN+i] = ext[i] ^ ext[i+PN-TAP];
    return ext[PN+WIDTH-1:PN];
  endfunction

  function automatic logic [EBW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [EBW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c = c + EBW'(v[i]);
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [PN-1:0]      seed_q, seed_d;
  logic [7:0]         clean_q, clean_d;
  logic [7:0]         bad_q, bad_d;
  logic [EBW-1:0]     err_bits_q, err_bits_d;
  logic               err_word_q, err_word_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic [WIDTH-1:0]   data_c, pred, mism;
  logic [EBW-1:0]     pop;
  logic [PN-1:0]      rx_seed, pr_seed;
  logic [SW-1:0]      esum;

  assign data_c  = i_data ^ {WIDTH{i_inv}};
  assign pred    = predict(seed_q);
  assign mism    = data_c ^ pred;
  assign pop     = popcount(mism);
  // Newest PN bits of a word seed the next word's prediction.
  assign rx_seed = data_c[WIDTH-1 -: PN];
  assign pr_seed = pred[WIDTH-1 -: PN];
  assign esum    = SW'(err_cnt_q) + SW'(pop);

  // Sync FSM: next state, seed and clean/bad run-length counters.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    clean_d = clean_q;
    bad_d   = bad_q;
    if (i_en) begin
      case (state_q)
        SEARCH: begin
          seed_d  = rx_seed;
          clean_d = '0;
          state_d = VERIFY;
        end
        VERIFY: begin
          seed_d = rx_seed;
          if (pop == '0) begin
            if (clean_q == 8'(LOCK_THR - 1)) begin
              state_d = LOCKED;
              clean_d = '0;
              bad_d   = '0;
            end else begin
              clean_d = clean_q + 8'd1;
            end
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Free-run from the prediction so a bit error is not re-seeded.
          seed_d = pr_seed;
          if (pop != '0) begin
            if (bad_q == 8'(UNLOCK_THR - 1)) begin
              state_d = SEARCH;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Per-word error report and saturating counters; clear wins over increment.
  always_comb begin
    err_bits_d = err_bits_q;
    err_word_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (i_en) begin
      err_bits_d = pop;
      err_word_d = |mism;
      if (state_q == LOCKED) begin
        err_cnt_d  = (|esum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : esum[CNT_W-1:0];
        word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1);
      end
    end
    if (i_clr_cnt) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      state_q    <= SEARCH;
      seed_q     <= '0;
      clean_q    <= '0;
      bad_q      <= '0;
      err_bits_q <= '0;
      err_word_q <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      clean_q    <= clean_d;
      bad_q      <= bad_d;
      err_bits_q <= err_bits_d;
      err_word_q <= err_word_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_lock     = (state_q == LOCKED);
  assign o_err_bits = err_bits_q;
  assign o_err_word = err_word_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs_wide_chk.sv
// tb_prbs_wide_chk: randomized and directed checks of prbs_wide_chk against
// a bit-level behavioural model; a second instance with 4-bit counters
// exercises saturation.
module tb_prbs_wide_chk;
  localparam int PN = 7, TAP = 6, W = 128, LT = 4, UT = 4, EBW = 8;
  localparam int ST_SEARCH = 0, ST_VERIFY = 1, ST_LOCKED = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, inv = 1'b0, clr = 1'b0;
  logic [W-1:0] data = '0;

  logic           lock, err_word, lock2, err_word2;
  logic [EBW-1:0] err_bits, err_bits2;
  logic [31:0]    err_cnt, word_cnt;
  logic [3:0]     err_cnt2, word_cnt2;

  prbs_wide_chk #(.PN(PN), .WIDTH(W), .LOCK_THR(LT), .UNLOCK_THR(UT), .CNT_W(32)) dut (
    .i_clk(clk), .i_s_rst(rst), .i_en(en), .i_data(data), .i_inv(inv), .i_clr_cnt(clr),
    .o_lock(lock), .o_err_bits(err_bits), .o_err_word(err_word),
    .o_err_cnt(err_cnt), .o_word_cnt(word_cnt));

  prbs_wide_chk #(.PN(PN), .WIDTH(W), .LOCK_THR(LT), .UNLOCK_THR(UT), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_s_rst(rst), .i_en(en), .i_data(data), .i_inv(inv), .i_clr_cnt(clr),
    .o_lock(lock2), .o_err_bits(err_bits2), .o_err_word(err_word2),
    .o_err_cnt(err_cnt2), .o_word_cnt(word_cnt2));

  int total = 0, bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference stream: PN7 bit sequence ----------------
  bit hist[$];
  task automatic next_word(output logic [W-1:0] w);
    bit b;
    for (int i = 0; i < W; i++) begin
      b = hist[0] ^ hist[PN-TAP];  // b[n] = b[n-7] ^ b[n-6]
      w[i] = b;
      void'(hist.pop_front());
      hist.push_back(b);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit [W-1:0] mpredict(input bit [PN-1:0] s);
    bit e[PN+W];
    bit [W-1:0] r;
    for (int i = 0; i < PN; i++) e[i] = s[i];
    for (int n = PN; n < PN + W; n++) e[n] = e[n-PN] ^ e[n-TAP];
    for (int i = 0; i < W; i++) r[i] = e[PN+i];
    return r;
  endfunction

  int        m_st = ST_SEARCH, m_clean = 0, m_bad = 0, m_bits = 0;
  bit        m_word = 1'b0;
  bit [PN-1:0] m_seed = '0;
  longint    etot = 0, wtot = 0;

  always @(posedge clk) begin : model_p
    bit [W-1:0] d, p;
    int n;
    if (rst) begin
      m_st = ST_SEARCH; m_seed = '0; m_clean = 0; m_bad = 0;
      m_bits = 0; m_word = 1'b0; etot = 0; wtot = 0;
    end else begin
      if (clr) begin etot = 0; wtot = 0; end
      if (en) begin
        d = data ^ {W{inv}};
        p = mpredict(m_seed);
        n = $countones(d ^ p);
        m_bits = n;
        m_word = (n != 0);
        if (m_st == ST_LOCKED && !clr) begin etot += n; wtot++; end
        case (m_st)
          ST_SEARCH: begin m_seed = d[W-1 -: PN]; m_clean = 0; m_st = ST_VERIFY; end
          ST_VERIFY: begin
            m_seed = d[W-1 -: PN];
            if (n == 0) begin
              m_clean++;
              if (m_clean == LT) begin m_st = ST_LOCKED; m_bad = 0; end
            end else m_st = ST_SEARCH;
          end
          default: begin
            m_seed = p[W-1 -: PN];
            if (n != 0) begin
              m_bad++;
              if (m_bad == UT) begin m_st = ST_SEARCH; m_bad = 0; end
            end else m_bad = 0;
          end
        endcase
      end else m_word = 1'b0;
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("lock", lock, m_st == ST_LOCKED);
      chk("err_bits", err_bits, m_bits);
      chk("err_word", err_word, m_word);
      chk("err_cnt", err_cnt, (etot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : etot);
      chk("word_cnt", word_cnt, (wtot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : wtot);
      chk("lock_s", lock2, m_st == ST_LOCKED);
      chk("err_bits_s", err_bits2, m_bits);
      chk("err_word_s", err_word2, m_word);
      chk("err_cnt_sat", err_cnt2, (etot > 15) ? 15 : etot);
      chk("word_cnt_sat", word_cnt2, (wtot > 15) ? 15 : wtot);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit e, input logic [W-1:0] d, input bit c);
    en = e; data = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic clean_word();
    logic [W-1:0] w;
    next_word(w);
    cyc(1'b1, w ^ {W{inv}}, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    int on_cnt;
    bit ever;
    for (int i = 0; i < PN; i++) hist.push_back(1'b1);

    rst = 1'b1;
    repeat (3) cyc(1'b1, '1, 1'b0);
    chk("rst_lock", lock, 0);
    chk("rst_err_bits", err_bits, 0);
    chk("rst_err_word", err_word, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_word_cnt", word_cnt, 0);
    cmp_on = 1'b1;
    rst = 1'b0;

    // Clean stream: lock after word 5, 995 counted words after 1000.
    for (int k = 1; k <= 1000; k++) begin
      clean_word();
      if (k == 4) chk("lock_w4", lock, 0);
      if (k == 5) chk("lock_w5", lock, 1);
    end
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_word_cnt", word_cnt, 995);

    // Single flipped bit counts exactly once.
    next_word(w);
    w[37] = ~w[37];
    cyc(1'b1, w, 1'b0);
    chk("b37_err_bits", err_bits, 1);
    chk("b37_err_word", err_word, 1);
    chk("b37_err_cnt", err_cnt, 1);
    chk("b37_lock", lock, 1);
    clean_word();
    chk("b37_next_word", err_word, 0);
    chk("b37_next_cnt", err_cnt, 1);

    // Random gaps, inversion changes, sparse bit errors and clears.
    repeat (400) begin
      if ($urandom_range(3, 0) == 0) begin
        cyc(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      end else begin
        inv = 1'($urandom_range(1, 0));
        next_word(w);
        if ($urandom_range(11, 0) == 0) w[$urandom_range(W-1, 0)] ^= 1'b1;
        cyc(1'b1, w ^ {W{inv}}, $urandom_range(49, 0) == 0);
      end
    end
    inv = 1'b0;

    // Reset mid-stream overrides en and clr.
    rst = 1'b1;
    next_word(w);
    cyc(1'b1, w, 1'b1);
    rst = 1'b0;
    chk("mrst_lock", lock, 0);
    chk("mrst_err_bits", err_bits, 0);
    chk("mrst_err_word", err_word, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    chk("mrst_word_cnt", word_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      clean_word();
      if (k == 4) chk("relock_w4", lock, 0);
      if (k == 5) chk("relock_w5", lock, 1);
    end

    // i_en toggled every 127 cycles while locked.
    next_word(w);
    cyc(1'b1, w, 1'b1);
    on_cnt = 0;
    for (int c = 0; c < 762; c++) begin
      if (((c / 127) % 2) == 0) begin
        clean_word();
        on_cnt++;
      end else begin
        cyc(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      end
    end
    chk("tog_word_cnt", word_cnt, on_cnt);
    chk("tog_err_cnt", err_cnt, 0);
    chk("tog_lock", lock, 1);

    // Clear coincident with a 3-bit error word.
    next_word(w);
    w[5] = ~w[5]; w[60] = ~w[60]; w[127] = ~w[127];
    cyc(1'b1, w, 1'b1);
    chk("clr3_err_cnt", err_cnt, 0);
    chk("clr3_word_cnt", word_cnt, 0);
    chk("clr3_err_bits", err_bits, 3);
    clean_word();

    // Four all-zero words drop lock, clean stream relocks.
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, '0, 1'b0);
      if (k == 3) chk("zero_w3_lock", lock, 1);
      if (k == 4) chk("zero_w4_lock", lock, 0);
    end
    for (int k = 1; k <= 5; k++) begin
      clean_word();
      if (k == 5) chk("zero_relock", lock, 1);
    end

    // Inverted stream without correction never locks.
    rst = 1'b1; cyc(1'b0, '0, 1'b0); rst = 1'b0;
    ever = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      next_word(w);
      cyc(1'b1, ~w, 1'b0);
      if (lock !== 1'b0) ever = 1'b1;
    end
    chk("inv_never_lock", ever, 0);

    // Same stream with correction locks after word 5.
    rst = 1'b1; cyc(1'b0, '0, 1'b0); rst = 1'b0;
    inv = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      next_word(w);
      cyc(1'b1, ~w, 1'b0);
      if (k == 4) chk("inv_lock_w4", lock, 0);
      if (k == 5) chk("inv_lock_w5", lock, 1);
    end
    repeat (3) cyc(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
